// File: rtl/polygon_vertex_loader.sv
// Per-frame polygon vertex loader: streams n vertices from BRAM into shadow
// arrays, then commits them to the fill datapath in one atomic cycle.
module polygon_vertex_loader #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 32,
    parameter int ADDR_BITS        = 10,
    parameter int READ_LATENCY     = 2,
    localparam int CNT_W           = $clog2(MAX_NUM_VERTICES + 1)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         frame_start_in,
    input  logic [ADDR_BITS-1:0]         base_addr_in,
    input  logic [CNT_W-1:0]             num_points_req_in,
    output logic [ADDR_BITS-1:0]         mem_addr_out,
    output logic                         mem_en_out,
    input  logic [2*WORLD_BITS-1:0]      mem_data_in,
    output logic signed [WORLD_BITS-1:0] xs_out [MAX_NUM_VERTICES],
    output logic signed [WORLD_BITS-1:0] ys_out [MAX_NUM_VERTICES],
    output logic [CNT_W-1:0]             num_points_out,
    output logic                         enable_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         error_out
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

    function automatic logic req_ok(input logic [CNT_W-1:0] n);
        return (n >= CNT_W'(3)) && (n <= CNT_W'(MAX_NUM_VERTICES));
    endfunction

    state_t                       state;
    state_t                       state_next;
    logic                         accept;
    logic                         reject;
    logic                         overrun;
    logic                         rd_vld;
    logic                         capture;
    logic                         last_capture;
    logic [ADDR_BITS-1:0]         base_lat;
    logic [CNT_W-1:0]             n_lat;
    logic [CNT_W-1:0]             issue_cnt;
    logic [CNT_W-1:0]             wr_cnt;
    logic [READ_LATENCY-1:0]      rd_vld_p;
    logic signed [WORLD_BITS-1:0] data_x;
    logic signed [WORLD_BITS-1:0] data_y;
    logic signed [WORLD_BITS-1:0] shadow_x [MAX_NUM_VERTICES];
    logic signed [WORLD_BITS-1:0] shadow_y [MAX_NUM_VERTICES];

    // Read-return stage: the tail of the valid shift register marks the cycle
    // in which mem_data_in holds the vertex addressed READ_LATENCY cycles ago.
    assign rd_vld       = rd_vld_p[READ_LATENCY-1];
    assign capture      = rd_vld && (state == FETCH || state == DRAIN);
    assign last_capture = capture && (wr_cnt == n_lat - CNT_W'(1));
    assign data_x       = $signed(mem_data_in[WORLD_BITS-1:0]);
    assign data_y       = $signed(mem_data_in[2*WORLD_BITS-1:WORLD_BITS]);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        reject     = 1'b0;
        overrun    = frame_start_in && (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_start_in) begin
                    if (req_ok(num_points_req_in)) begin
                        accept     = 1'b1;
                        state_next = FETCH;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (issue_cnt == n_lat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the edge that captures the final vertex so COMMIT
                // sees a complete shadow array.
                if (last_capture) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Issue stage: address and enable are registered, so address i is on the
    // bus in the i-th cycle after the request is accepted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_out     <= 1'b0;
            done_out     <= 1'b0;
            error_out    <= 1'b0;
            mem_en_out   <= 1'b0;
            mem_addr_out <= '0;
            base_lat     <= '0;
            n_lat        <= '0;
            issue_cnt    <= '0;
            wr_cnt       <= '0;
            rd_vld_p     <= '0;
        end else begin
            busy_out  <= (state_next != IDLE);
            done_out  <= (state == COMMIT);
            error_out <= reject || overrun;
            rd_vld_p  <= (rd_vld_p << 1) | READ_LATENCY'(mem_en_out);

            if (accept) begin
                base_lat     <= base_addr_in;
                n_lat        <= num_points_req_in;
                mem_en_out   <= 1'b1;
                mem_addr_out <= base_addr_in;
                issue_cnt    <= CNT_W'(1);
            end else if (state == FETCH) begin
                if (issue_cnt == n_lat) begin
                    mem_en_out <= 1'b0;
                end else begin
                    mem_addr_out <= base_lat + ADDR_BITS'(issue_cnt);
                    issue_cnt    <= issue_cnt + CNT_W'(1);
                end
            end

            if (accept) begin
                wr_cnt <= '0;
            end else if (capture) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    // Shadow/commit stage: outputs change only on the COMMIT edge, all at once.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < MAX_NUM_VERTICES; k++) begin
                shadow_x[k] <= '0;
                shadow_y[k] <= '0;
                xs_out[k]   <= '0;
                ys_out[k]   <= '0;
            end
            num_points_out <= '0;
            enable_out     <= 1'b0;
        end else begin
            if (capture) begin
                for (int k = 0; k < MAX_NUM_VERTICES; k++) begin
                    if (wr_cnt == CNT_W'(k)) begin
                        shadow_x[k] <= data_x;
                        shadow_y[k] <= data_y;
                    end
                end
            end
            if (state == COMMIT) begin
                xs_out         <= shadow_x;
                ys_out         <= shadow_y;
                num_points_out <= n_lat;
                enable_out     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_polygon_vertex_loader.sv
// Scoreboard bench for polygon_vertex_loader: expected reads and commits are
// queued when a request is driven and retired as the DUT produces them.
module tb_polygon_vertex_loader;

    localparam int WB   = 32;
    localparam int MAXV = 32;
    localparam int AB   = 10;
    localparam int RL   = 2;
    localparam int CW   = $clog2(MAXV + 1);

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 frame_start_in;
    logic [AB-1:0]        base_addr_in;
    logic [CW-1:0]        num_points_req_in;
    logic [AB-1:0]        mem_addr_out;
    logic                 mem_en_out;
    logic [2*WB-1:0]      mem_data_in;
    logic signed [WB-1:0] xs_out [MAXV];
    logic signed [WB-1:0] ys_out [MAXV];
    logic [CW-1:0]        num_points_out;
    logic                 enable_out;
    logic                 busy_out;
    logic                 done_out;
    logic                 error_out;

    polygon_vertex_loader #(
        .WORLD_BITS(WB), .MAX_NUM_VERTICES(MAXV), .ADDR_BITS(AB), .READ_LATENCY(RL)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
        .base_addr_in(base_addr_in), .num_points_req_in(num_points_req_in),
        .mem_addr_out(mem_addr_out), .mem_en_out(mem_en_out), .mem_data_in(mem_data_in),
        .xs_out(xs_out), .ys_out(ys_out), .num_points_out(num_points_out),
        .enable_out(enable_out), .busy_out(busy_out), .done_out(done_out),
        .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // BRAM model with RL-cycle read latency
    logic [2*WB-1:0] mem [1 << AB];
    logic [2*WB-1:0] pipe [RL];
    always @(posedge clk_in) begin
        pipe[0] <= mem_en_out ? mem[mem_addr_out] : 64'hBAD0_0BAD_BAD0_0BAD;
        for (int s = 1; s < RL; s++) pipe[s] <= pipe[s-1];
    end
    assign mem_data_in = pipe[RL-1];

    typedef struct { logic [AB-1:0] addr; int cyc; } rd_t;
    typedef struct { int n; int cyc; } cm_t;
    rd_t             rd_q[$];
    cm_t             cm_q[$];
    logic [2*WB-1:0] vtx_q[$];
    rd_t             rd_e;
    cm_t             cm_e;
    logic [2*WB-1:0] vtx_e;

    function automatic logic [2*WB-1:0] pack(input int x, input int y);
        return {y, x};
    endfunction

    // Read-address scoreboard consumer
    always @(negedge clk_in) begin
        if (mem_en_out === 1'b1) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected cyc=%0d got addr=%h want no read", cyc, mem_addr_out);
            end else begin
                rd_e = rd_q.pop_front();
                if (mem_addr_out !== rd_e.addr || cyc != rd_e.cyc) begin
                    miscompares++;
                    $display("FAIL rd_addr got addr=%h cyc=%0d want addr=%h cyc=%0d",
                             mem_addr_out, cyc, rd_e.addr, rd_e.cyc);
                end
            end
        end
    end

    // Commit scoreboard consumer
    always @(negedge clk_in) begin
        if (done_out === 1'b1) begin
            vectors++;
            if (cm_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected cyc=%0d got done=1 want 0", cyc);
            end else begin
                cm_e = cm_q.pop_front();
                if (cyc != cm_e.cyc || num_points_out !== CW'(cm_e.n) || enable_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL commit got cyc=%0d n=%0d en=%b want cyc=%0d n=%0d en=1",
                             cyc, num_points_out, enable_out, cm_e.cyc, cm_e.n);
                end
                for (int k = 0; k < cm_e.n && k < MAXV; k++) begin
                    vectors++;
                    if (vtx_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL vertex_queue_empty k=%0d", k);
                    end else begin
                        vtx_e = vtx_q.pop_front();
                        if (xs_out[k] !== vtx_e[WB-1:0] || ys_out[k] !== vtx_e[2*WB-1:WB]) begin
                            miscompares++;
                            $display("FAIL vertex[%0d] got (%0d,%0d) want (%0d,%0d)", k,
                                     xs_out[k], ys_out[k],
                                     $signed(vtx_e[WB-1:0]), $signed(vtx_e[2*WB-1:WB]));
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    // Drives a one-cycle frame_start in the current cycle; returns in cycle t+1.
    task automatic start(input logic [AB-1:0] base, input int n, input bit push, output int t);
        logic [AB-1:0] a;
        frame_start_in    = 1'b1;
        base_addr_in      = base;
        num_points_req_in = CW'(n);
        t = cyc;
        if (push) begin
            for (int i = 0; i < n; i++) begin
                a = base + AB'(i);
                rd_q.push_back('{a, t + 1 + i});
                vtx_q.push_back(mem[a]);
            end
            cm_q.push_back('{n, t + n + RL + 2});
        end
        tick();
        frame_start_in    = 1'b0;
        base_addr_in      = '0;
        num_points_req_in = '0;
    endtask

    task automatic test_reset();
        logic nz;
        rst_in = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_in);
            vectors++;
            if ({num_points_out, enable_out, busy_out, done_out, error_out, mem_en_out, mem_addr_out} !== '0) begin
                miscompares++;
                $display("FAIL reset_ctrl cyc=%0d got np=%0d en=%b busy=%b done=%b err=%b men=%b addr=%h want all 0",
                         cyc, num_points_out, enable_out, busy_out, done_out, error_out, mem_en_out, mem_addr_out);
            end
            nz = 1'b0;
            for (int k = 0; k < MAXV; k++) if (xs_out[k] !== '0 || ys_out[k] !== '0) nz = 1'b1;
            vectors++;
            if (nz !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_arrays cyc=%0d got nonzero vertex want all 0", cyc);
            end
            tick();
        end
    endtask

    task automatic test_square();
        int t;
        int ex[4] = '{0, 100, 100, 0};
        int ey[4] = '{0, 0, -50, -50};
        start(10'h010, 4, 1'b1, t);
        @(negedge clk_in);
        vectors++;
        if (busy_out !== 1'b1 || error_out !== 1'b0) begin
            miscompares++;
            $display("FAIL square_busy got busy=%b err=%b want busy=1 err=0", busy_out, error_out);
        end
        go_to(t + 4 + RL + 1);
        @(negedge clk_in);
        vectors++;
        if (busy_out !== 1'b1 || done_out !== 1'b0 || enable_out !== 1'b0 || num_points_out !== '0) begin
            miscompares++;
            $display("FAIL square_precommit got busy=%b done=%b en=%b np=%0d want 1 0 0 0",
                     busy_out, done_out, enable_out, num_points_out);
        end
        tick();
        @(negedge clk_in);
        vectors++;
        if (done_out !== 1'b1 || busy_out !== 1'b0 || num_points_out !== CW'(4)) begin
            miscompares++;
            $display("FAIL square_done got done=%b busy=%b np=%0d want 1 0 4", done_out, busy_out, num_points_out);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (xs_out[k] !== 32'(ex[k]) || ys_out[k] !== 32'(ey[k])) begin
                miscompares++;
                $display("FAIL square_v%0d got (%0d,%0d) want (%0d,%0d)", k, xs_out[k], ys_out[k], ex[k], ey[k]);
            end
        end
        tick();
    endtask

    task automatic test_invalid();
        int t;
        int bad[2] = '{2, 33};
        for (int b = 0; b < 2; b++) begin
            start(10'h020, bad[b], 1'b0, t);
            @(negedge clk_in);
            vectors++;
            if (error_out !== 1'b1 || busy_out !== 1'b0) begin
                miscompares++;
                $display("FAIL invalid_n%0d_err got err=%b busy=%b want err=1 busy=0", bad[b], error_out, busy_out);
            end
            tick();
            @(negedge clk_in);
            vectors++;
            if (error_out !== 1'b0 || num_points_out !== CW'(4) || xs_out[1] !== 32'sd100 || enable_out !== 1'b1) begin
                miscompares++;
                $display("FAIL invalid_n%0d_keep got err=%b np=%0d x1=%0d en=%b want 0 4 100 1",
                         bad[b], error_out, num_points_out, xs_out[1], enable_out);
            end
            tick();
        end
    endtask

    task automatic test_overrun();
        int t;
        int t2;
        start(10'h040, 5, 1'b1, t);
        go_to(t + 3);
        start(10'h080, 3, 1'b0, t2);
        @(negedge clk_in);
        vectors++;
        if (error_out !== 1'b1 || busy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_err got err=%b busy=%b want err=1 busy=1", error_out, busy_out);
        end
        tick();
        @(negedge clk_in);
        vectors++;
        if (error_out !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_pulse got err=%b want 0", error_out);
        end
        go_to(t + 5 + RL + 3);
    endtask

    task automatic test_wrap();
        int t;
        start(10'h3FE, 4, 1'b1, t);
        go_to(t + 4 + RL + 3);
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        start(10'h100, 3, 1'b1, t1);
        go_to(t1 + 3 + RL + 2);
        start(10'h200, 6, 1'b1, t2);
        @(negedge clk_in);
        vectors++;
        if (busy_out !== 1'b1 || error_out !== 1'b0 || num_points_out !== CW'(3)) begin
            miscompares++;
            $display("FAIL b2b_accept got busy=%b err=%b np=%0d want 1 0 3", busy_out, error_out, num_points_out);
        end
        go_to(t2 + 6 + RL + 3);
    endtask

    task automatic test_reset_mid_load();
        int t;
        logic [AB-1:0] a;
        start(10'h300, 8, 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            a = 10'h300 + AB'(i);
            rd_q.push_back('{a, t + 1 + i});
        end
        go_to(t + 3);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        @(negedge clk_in);
        vectors++;
        if ({num_points_out, enable_out, busy_out, done_out, error_out, mem_en_out} !== '0
            || xs_out[0] !== '0 || ys_out[2] !== '0) begin
            miscompares++;
            $display("FAIL midreset got np=%0d en=%b busy=%b done=%b err=%b men=%b x0=%0d want all 0",
                     num_points_out, enable_out, busy_out, done_out, error_out, mem_en_out, xs_out[0]);
        end
        go_to(cyc + 12);
        start(10'h300, 8, 1'b1, t);
        go_to(t + 8 + RL + 3);
        @(negedge clk_in);
        vectors++;
        if (enable_out !== 1'b1 || num_points_out !== CW'(8)) begin
            miscompares++;
            $display("FAIL midreset_reload got en=%b np=%0d want 1 8", enable_out, num_points_out);
        end
        tick();
    endtask

    task automatic test_final();
        vectors++;
        if (rd_q.size() != 0 || cm_q.size() != 0 || vtx_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got rd=%0d cm=%0d vtx=%0d pending want 0 0 0",
                     rd_q.size(), cm_q.size(), vtx_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d bench did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in            = 1'b1;
        frame_start_in    = 1'b0;
        base_addr_in      = '0;
        num_points_req_in = '0;
        for (int a = 0; a < (1 << AB); a++) mem[a] = pack(a * 37 - 9000, 4000 - a * 91);
        mem[16] = pack(0, 0);
        mem[17] = pack(100, 0);
        mem[18] = pack(100, -50);
        mem[19] = pack(0, -50);

        test_reset();
        test_square();
        test_invalid();
        test_overrun();
        test_wrap();
        test_back_to_back();
        test_reset_mid_load();
        test_final();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
